hamming_secded_stream: RTL
==========================

Name: hamming_secded_stream

Overview:
- Parametrised, pipelined SECDED codec: extended Hamming over DATA_W data bits, with valid/ready streaming and an error-injection mask.
- Each accepted word is encoded, XORed with the caller's noise mask, decoded, corrected and classified.
- Successor to the fixed 7,4 combinational top. Adds arbitrary width, backpressure, a 3-stage pipeline and saturating error statistics.
- Used as the lab/demo datapath and as a reusable ECC core for memories.

Parameters:
- DATA_W, 8, data bits per word (range 4..64).
- CNT_W, 16, width of each saturating error counter.
- Derived, not overridable:
  - P = smallest integer with 2^P >= DATA_W+P+1.
  - N = DATA_W+P.
  - CODE_W = N+1.
  - For DATA_W=8: P=4, N=12, CODE_W=13.

Ports:
- in_clk  in  1  clock, all logic on rising edge.
- in_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- out_ready_in  out  1  block can accept a word this cycle (ready to upstream).
- in_data  in  DATA_W  data word.
- in_noise  in  CODE_W  error-injection mask.
  - Bit 0 = overall parity bit.
  - Bit k = codeword position k (1..N).
- out_valid  out  1  result valid.
- in_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  corrected (or raw, if uncorrectable) data.
- out_1bit_error  out  1  single error corrected (data or Hamming parity bit).
- out_2bit_error  out  1  uncorrectable error detected.
- out_parity_error  out  1  only the overall parity bit was flipped.
- out_syndrome  out  P  raw syndrome of the result word.
- in_cnt_clr  in  1  synchronous clear of both counters.
- out_cnt_1bit  out  CNT_W  saturating count of out_1bit_error results.
- out_cnt_2bit  out  CNT_W  saturating count of out_2bit_error results.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, every output and counter 0.
  - In-flight words are dropped.
  - out_ready_in is 0 while reset is asserted.
- Codeword layout:
  - Hamming parity bits sit at power-of-two positions 1,2,4,...
  - Data bits fill the remaining positions 3,5,6,7,9... in ascending order, in_data[0] first.
  - Parity bit 2^j = XOR of all positions with bit j set.
  - Position 0 = even parity over positions 1..N.
- Pipeline: advance = !out_valid || in_ready; out_ready_in = advance.
  - All three stages shift together on advance; otherwise every stage holds.
  - S1 captures the encoded word XOR in_noise, with valid = in_valid.
  - S2 captures syndrome s (P bits), overall mismatch p, and the received word.
  - S3 captures the corrected data, flags, out_syndrome and out_valid.
- Latency is 3 cycles from accept to out_valid with no stall. Throughput is 1 word/cycle.
- Bubbles propagate as valid=0. Flags are 0 whenever out_valid=0.
- Classification:
  - s=0, p=0: clean. All flags 0.
  - s=0, p=1: out_parity_error=1. Data unchanged.
  - s!=0, p=1, s<=N: flip position s, out_1bit_error=1.
  - s!=0, p=1, s>N: out_2bit_error=1. Data uncorrected.
  - s!=0, p=0: out_2bit_error=1. Data uncorrected.
  - Exactly one flag is set at most.
- Counters:
  - Each increments on an out_valid && in_ready transfer carrying its flag.
  - Each saturates at 2^CNT_W-1.
  - in_cnt_clr forces 0 and wins over a simultaneous increment.
- Data and ordering are never lost or reordered under any stall pattern.

Optional Feature:
- HAMMING_SECDED_7SEG_EN defined: adds output out_7seg[6:0], active-high, segments gfedcba.
  - Registered on each output transfer; shows hex digit out_data[3:0].
  - Encoding 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - Reset value 3F.
- Undefined: port and logic are absent.

Decomposition:
- Package hamming_secded_pkg:
  - function calc_p(DATA_W).
  - Function mapping data index to code position.
  - Flag-encoding constants.
  - 16-entry 7-seg lookup constant.
- One sub-module, hamming_secded_enc: combinational parametrised encoder (data in, CODE_W codeword out). Reused by memory wrappers.

Test Plan (DATA_W=8, CNT_W=16 unless noted):
1. Data 0x00..0xFF, noise 0, in_ready=1 -> out_data equal to input 3 cycles later, all flags 0, back-to-back throughput.
2. Data 0xA5, noise bit k for each k=1..12 -> out_data 0xA5, out_1bit_error=1, out_syndrome=k, out_cnt_1bit=12.
3. Data 0xA5, noise bit 0 -> out_data 0xA5, out_parity_error=1, syndrome 0. Noise bits 3 and 5 -> out_2bit_error=1, syndrome 6, out_cnt_2bit=1.
4. Data 0x3C, noise bits 1, 4, 8 (s=13>N, p=1) -> out_2bit_error=1, out_1bit_error=0, data not modified by correction.
5. Push 6 words 0x01..0x06; hold in_ready=0 for 5 cycles starting cycle 2 -> out_ready_in drops once 3 words are held; all 6 emerge in order, none duplicated.
6. CNT_W=2: five single-error words -> out_cnt_1bit=3. Assert in_cnt_clr alongside a sixth error transfer -> 0. Async reset mid-stream -> out_valid 0 immediately, counters 0.

Source files
------------

// File: rtl/hamming_secded_pkg.sv
// Shared types and helpers for the SECDED stream codec.
// Optional 7-segment output: HAMMING_SECDED_7SEG_EN.
package hamming_secded_pkg;

  typedef enum logic [1:0] {
    FLG_NONE = 2'd0,
    FLG_1BIT = 2'd1,
    FLG_2BIT = 2'd2,
    FLG_PAR  = 2'd3
  } flag_e;

  // gfedcba, index = hex digit
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int calc_p(input int dw);
    int p;
    p = 0;
    for (int q = 7; q >= 1; q--)
      if ((1 << q) >= dw + q + 1) p = q;
    return p;
  endfunction

  // Data index -> code position, skipping powers of two
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = -1;
    pos = 0;
    for (int k = 1; k < 128; k++)
      if ((k & (k - 1)) != 0) begin
        cnt++;
        if (cnt == idx) pos = k;
      end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_enc.sv
// Combinational extended-Hamming encoder.
// Bit 0 is overall even parity over positions 1..N.
module hamming_secded_enc
  import hamming_secded_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int P = calc_p(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  logic [CODE_W-1:0] raw;
  logic [P-1:0]      par;

  always_comb begin
    raw = '0;
    for (int i = 0; i < DATA_W; i++)
      raw[data_pos(i)] = data[i];
    par = '0;
    for (int j = 0; j < P; j++)
      for (int k = 1; k < CODE_W; k++)
        if (k[j]) par[j] ^= raw[k];
    code = raw;
    for (int j = 0; j < P; j++)
      code[1 << j] = par[j];
    code[0] = ^code[CODE_W-1:1];
  end

endmodule

// File: rtl/hamming_secded_stream.sv
// 3-stage SECDED encode/inject/decode pipeline with stats.
// Optional 7-segment output: HAMMING_SECDED_7SEG_EN.
module hamming_secded_stream
  import hamming_secded_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int N      = DATA_W + P,
  localparam int CODE_W = N + 1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  output logic              out_ready_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_noise,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_1bit_error,
  output logic              out_2bit_error,
  output logic              out_parity_error,
  output logic [P-1:0]      out_syndrome,
  input  logic              in_cnt_clr,
  output logic [CNT_W-1:0]  out_cnt_1bit,
  output logic [CNT_W-1:0]  out_cnt_2bit
`ifdef HAMMING_SECDED_7SEG_EN
  ,
  output logic [6:0]        out_7seg
`endif
);

  localparam logic [P-1:0]     N_LIM   = P'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              adv;
  logic              xfer;
  logic [CODE_W-1:0] enc_code;

  logic              v1;
  logic [CODE_W-1:0] w1;
  logic              v2;
  logic [P-1:0]      s2;
  logic              p2;
  logic [DATA_W-1:0] d2;

  logic [P-1:0]      syn;
  logic              pm;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] cdata;
  flag_e             flag;

  assign adv          = !out_valid || in_ready;
  assign out_ready_in = in_rst_n && adv;
  assign xfer         = out_valid && in_ready;

  hamming_secded_enc #(.DATA_W(DATA_W)) u_enc (
    .data (in_data),
    .code (enc_code)
  );

  always_comb begin
    syn = '0;
    for (int k = 1; k <= N; k++)
      if (w1[k]) syn ^= P'(k);
    pm = ^w1;
    rdata = '0;
    for (int i = 0; i < DATA_W; i++)
      rdata[i] = w1[data_pos(i)];
  end

  always_comb begin
    flag  = FLG_NONE;
    cdata = d2;
    unique case (1'b1)
      (s2 == '0 && !p2): flag = FLG_NONE;
      (s2 == '0 && p2):  flag = FLG_PAR;
      (s2 != '0 && p2 && s2 <= N_LIM): begin
        flag = FLG_1BIT;
        for (int i = 0; i < DATA_W; i++)
          if (s2 == P'(data_pos(i)))
            cdata[i] = ~d2[i];
      end
      default: flag = FLG_2BIT;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      v1               <= 1'b0;
      w1               <= '0;
      v2               <= 1'b0;
      s2               <= '0;
      p2               <= 1'b0;
      d2               <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_1bit_error   <= 1'b0;
      out_2bit_error   <= 1'b0;
      out_parity_error <= 1'b0;
      out_syndrome     <= '0;
    end else if (adv) begin
      v1               <= in_valid;
      w1               <= enc_code ^ in_noise;
      v2               <= v1;
      s2               <= syn;
      p2               <= pm;
      d2               <= rdata;
      out_valid        <= v2;
      out_data         <= cdata;
      out_1bit_error   <= v2 && flag == FLG_1BIT;
      out_2bit_error   <= v2 && flag == FLG_2BIT;
      out_parity_error <= v2 && flag == FLG_PAR;
      out_syndrome     <= s2;
    end
  end

  // Clear beats a same-cycle increment
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_cnt_1bit <= '0;
      out_cnt_2bit <= '0;
    end else if (in_cnt_clr) begin
      out_cnt_1bit <= '0;
      out_cnt_2bit <= '0;
    end else if (xfer) begin
      if (out_1bit_error && out_cnt_1bit != CNT_MAX)
        out_cnt_1bit <= out_cnt_1bit + 1'b1;
      if (out_2bit_error && out_cnt_2bit != CNT_MAX)
        out_cnt_2bit <= out_cnt_2bit + 1'b1;
    end
  end

`ifdef HAMMING_SECDED_7SEG_EN
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)
      out_7seg <= 7'h3F;
    else if (xfer)
      out_7seg <= SEG_LUT[out_data[3:0]];
  end
`endif

endmodule
